// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller and its
// digit register file.
package seven_seg_pkg;

    typedef enum logic [0:0] {GUARD, SHOW} scan_state_t;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = $clog2(NUM_DIGITS);

    typedef logic [3:0]       hex_t;
    typedef logic [SEL_W-1:0] digit_idx_t;

    // Digit order 0..7 wraps naturally in the 3-bit index.
    function automatic digit_idx_t next_digit(input digit_idx_t d);
        return d + digit_idx_t'(1);
    endfunction

endpackage

// File: rtl/seven_seg_digit_rf.sv
// 8 x 4-bit digit register file: one write port and one combinational read
// port that forwards a same-cycle write to the addressed digit.
module seven_seg_digit_rf
    import seven_seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [2:0] rd_addr,
    output logic [3:0] rd_data
);

    hex_t                  digit_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] wr_hit;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_wr_decode
            assign wr_hit[gi] = wr_en && (wr_addr == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_hit[i]) begin
                    digit_reg[i] <= wr_data;
                end
            end
        end
    end

    // Forwarding lets the caller register the value that will be stored.
    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : digit_reg[rd_addr];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display with
// a blanking guard interval at the start of every digit slot.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] digit_en,
    output logic [3:0] num,
    output logic [2:0] sel,
    output logic       blank,
    output logic       frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam digit_idx_t    LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    scan_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    digit_idx_t    sel_reg, sel_next;
    hex_t          num_reg, num_next;
    logic          blank_reg, blank_next;
    logic          frame_reg, frame_next;

    seven_seg_digit_rf u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (sel_next),
        .rd_data (num_next)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        blank_next = 1'b1;
        frame_next = 1'b0;
        if (scan_en) begin
            case (state_reg)
                GUARD: begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == GUARD_LAST) begin
                        state_next = SHOW;
                        blank_next = ~digit_en[sel_reg];
                    end
                end
                SHOW: begin
                    if (cnt_reg == SLOT_LAST) begin
                        cnt_next   = '0;
                        sel_next   = next_digit(sel_reg);
                        state_next = GUARD;
                        frame_next = (sel_reg == LAST_DIGIT);
                    end else begin
                        cnt_next   = cnt_reg + CW'(1);
                        blank_next = ~digit_en[sel_reg];
                    end
                end
                default: begin
                    state_next = GUARD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= GUARD;
            cnt_reg   <= '0;
            sel_reg   <= '0;
            num_reg   <= '0;
            blank_reg <= 1'b1;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            num_reg   <= num_next;
            blank_reg <= blank_next;
            frame_reg <= frame_next;
        end
    end

    assign num        = num_reg;
    assign sel        = sel_reg;
    assign blank      = blank_reg;
    assign frame_done = frame_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with D=10, G=2; expected outputs come
// from a small slot/frame model advanced only on edges where scanning runs.
module tb_seven_seg_scan_ctrl;

    localparam int D = 10;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] digit_en;
    logic [3:0] num;
    logic [2:0] sel;
    logic       blank;
    logic       frame_done;

    int         compared   = 0;
    int         mismatched = 0;
    int         t;
    bit         frozen;
    logic [3:0] mdl [8];

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV  (D),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_en    (scan_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_en   (digit_en),
        .num        (num),
        .sel        (sel),
        .blank      (blank),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Expected outputs for scan time t: slot index t/D, guard for the first G counts.
    task automatic check_cycle();
        int   s;
        logic eb;
        logic ef;
        s  = (t / D) % 8;
        eb = frozen || ((t % D) < G) || !digit_en[s];
        ef = !frozen && (t > 0) && ((t % (8 * D)) == 0);
        check("sel",        8'(sel),        8'(s));
        check("blank",      8'(blank),      8'(eb));
        check("num",        8'(num),        8'(mdl[s]));
        check("frame_done", 8'(frame_done), 8'(ef));
    endtask

    task automatic tick();
        if (wr_en) mdl[wr_addr] = wr_data;
        if (scan_en) t++;
        frozen = !scan_en;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            check_cycle();
            tick();
        end
    endtask

    task automatic model_reset();
        t      = 0;
        frozen = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 4'h0;
    endtask

    initial begin
        rst_n    = 1'b0;
        scan_en  = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 4'h0;
        digit_en = 8'hFF;
        model_reset();

        @(posedge clk);
        #1;
        $display("step reset: held in reset");
        check_cycle();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        $display("step scan: one full frame plus a slot");
        run(90);

        $display("step write: 0xA to digit 3, observe sel=3 slot");
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        run(40);

        $display("step live write: 0x5 to digit 2 during its SHOW");
        run(184 - t);
        check_cycle();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h5;
        tick();
        wr_en = 1'b0;
        check("live_num",   8'(num),   8'h05);
        check("live_blank", 8'(blank), 8'h00);

        $display("step mask: digit 0 disabled");
        digit_en = 8'b1111_1110;
        run(75);
        digit_en = 8'hFF;

        $display("step freeze: scan_en low at count 5 of sel=4 slot");
        run(285 - t);
        scan_en = 1'b0;
        tick();
        run(9);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'h7;
        run(1);
        wr_en = 1'b0;
        run(9);
        check("frozen_sel",   8'(sel),   8'h04);
        check("frozen_blank", 8'(blank), 8'h01);
        check("frozen_num",   8'(num),   8'h07);
        scan_en = 1'b1;
        run(4);
        check("resume_sel", 8'(sel), 8'h04);

        $display("step switch write: 0xC to digit 5 on the 4->5 edge");
        check_cycle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hC;
        tick();
        wr_en = 1'b0;
        check("switch_sel", 8'(sel), 8'h05);
        check("switch_num", 8'(num), 8'h0C);
        run(15);

        $display("step async reset: mid-SHOW on sel=6");
        check("pre_rst_sel", 8'(sel), 8'h06);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_num",   8'(num),        8'h00);
        check("rst_sel",   8'(sel),        8'h00);
        check("rst_blank", 8'(blank),      8'h01);
        check("rst_frame", 8'(frame_done), 8'h00);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
